pwm_meter: RTL and testbench

Digital PWM measurement block for the emulator fabric: samples a single-bit waveform in the `emu_clk` domain and reports each complete period and high time as cycle counts. It is the receive-side counterpart of the PWM stimulus that drives switch control inputs such as `ctrl`. It feeds duty-cycle and frequency checks on comparator and switch outputs back to the host-side probes through a valid/ready handshake.

---
 rtl/pwm_meter.sv | 170 +++++++++++++++++
 tb/tb_pwm_meter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_meter.sv
// pwm_meter: measures the period and high time of a single-bit waveform
// in emu_clk cycles. Results go out through a valid/ready handshake.
// Optional feature macro: PWM_METER_SYNC_EN adds a 2-flop input synchronizer.
// Without it, sig_in is used directly and must be synchronous to emu_clk.
module pwm_meter #(
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 1048576
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] meas_period,
  output logic [CNT_WIDTH-1:0] meas_high,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  output logic                 overrun,
  output logic                 timeout,
  output logic                 stuck_level
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // The timeout limit is an int, so compare in at least 32 bits to avoid
  // truncating it when the counters are narrow.
  localparam int                CMP_W       = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;
  localparam logic [CMP_W-1:0]  TIMEOUT_LIM = CMP_W'(TIMEOUT);

  logic                 sig_s;
  logic                 sig_p;
  logic                 rise;
  logic                 fall;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt_high;
  logic [CNT_WIDTH-1:0] cnt_low;
  logic [CNT_WIDTH-1:0] cnt_high_inc;
  logic [CNT_WIDTH-1:0] cnt_low_inc;
  logic [CNT_WIDTH:0]   sum_full;
  logic [CNT_WIDTH-1:0] sum_sat;
  logic                 complete;
  logic                 timeout_hit;
  logic                 timeout_fire;

`ifdef PWM_METER_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // Two-flop synchronizer bringing an asynchronous sig_in into emu_clk.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sig_in;
      sync_q2 <= sync_q1;
    end
  end

  assign sig_s = sync_q2;
`else
  assign sig_s = sig_in;
`endif

  // One-cycle delayed copy of the sampled input for edge detection.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) sig_p <= 1'b0;
    else         sig_p <= sig_s;
  end

  assign rise = ~sig_p &  sig_s;
  assign fall =  sig_p & ~sig_s;

  // Counters and their sum saturate instead of wrapping, so an overlong
  // period reads as the maximum value rather than a small bogus number.
  assign cnt_high_inc = (cnt_high == CNT_MAX) ? CNT_MAX : cnt_high + CNT_ONE;
  assign cnt_low_inc  = (cnt_low  == CNT_MAX) ? CNT_MAX : cnt_low  + CNT_ONE;
  assign sum_full     = {1'b0, cnt_high} + {1'b0, cnt_low};
  assign sum_sat      = sum_full[CNT_WIDTH] ? CNT_MAX : sum_full[CNT_WIDTH-1:0];

  // A period closing on the same cycle the limit is reached counts as a
  // completed period, so completion takes priority over the timeout.
  assign complete     = (state == ST_LOW) && rise;
  assign timeout_hit  = (TIMEOUT != 0) && (state != ST_IDLE) &&
                        (CMP_W'(sum_sat) >= TIMEOUT_LIM);
  assign timeout_fire = timeout_hit && !complete;

  // Measurement FSM: IDLE waits for a first rise, HIGH/LOW count the phases.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state    <= ST_IDLE;
      cnt_high <= '0;
      cnt_low  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state    <= ST_HIGH;
            cnt_high <= CNT_ONE;
            cnt_low  <= '0;
          end
        end
        ST_HIGH: begin
          if (timeout_fire) begin
            state    <= ST_IDLE;
            cnt_high <= '0;
            cnt_low  <= '0;
          end else if (fall) begin
            state   <= ST_LOW;
            cnt_low <= CNT_ONE;
          end else begin
            cnt_high <= cnt_high_inc;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state    <= ST_HIGH;
            cnt_high <= CNT_ONE;
            cnt_low  <= '0;
          end else if (timeout_fire) begin
            state    <= ST_IDLE;
            cnt_high <= '0;
            cnt_low  <= '0;
          end else begin
            cnt_low <= cnt_low_inc;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cnt_high <= '0;
          cnt_low  <= '0;
        end
      endcase
    end
  end

  // Result register, handshake, and the one-cycle overrun/timeout pulses.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      meas_period <= '0;
      meas_high   <= '0;
      meas_valid  <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      if (timeout_fire) begin
        timeout     <= 1'b1;
        stuck_level <= sig_s;
      end
      if (complete) begin
        if (!meas_valid || meas_ready) begin
          meas_period <= sum_sat;
          meas_high   <= cnt_high;
          meas_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_meter.sv
// tb_pwm_meter: scoreboard bench for pwm_meter. Stimulus pushes expected
// results and timeouts into queues; monitors pop and compare on DUT outputs.
// Honours PWM_METER_SYNC_EN by shifting expected latencies by 2 cycles.
module tb_pwm_meter;

  localparam int CNT_WIDTH = 32;
  localparam int TIMEOUT   = 16;
`ifdef PWM_METER_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif
  localparam int LAT = SYNC_DLY + 1;

  typedef struct {
    int unsigned period;
    int unsigned high;
    int          cyc;
  } meas_t;

  typedef struct {
    int   cyc;
    logic level;
  } to_t;

  logic                 emu_clk = 1'b0;
  logic                 emu_rst;
  logic                 sig_in;
  logic                 meas_ready;
  logic [CNT_WIDTH-1:0] meas_period;
  logic [CNT_WIDTH-1:0] meas_high;
  logic                 meas_valid;
  logic                 overrun;
  logic                 timeout;
  logic                 stuck_level;

  meas_t exp_q[$];
  to_t   to_q[$];
  meas_t mon_m;
  to_t   mon_t;
  int    n_checks    = 0;
  int    n_errors    = 0;
  int    cyc         = 0;
  int    overrun_cnt = 0;

  pwm_meter #(
    .CNT_WIDTH(CNT_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .emu_clk    (emu_clk),
    .emu_rst    (emu_rst),
    .sig_in     (sig_in),
    .meas_period(meas_period),
    .meas_high  (meas_high),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .overrun    (overrun),
    .timeout    (timeout),
    .stuck_level(stuck_level)
  );

  // Free-running clock and cycle index used for latency expectations.
  always #5 emu_clk = ~emu_clk;

  always @(posedge emu_clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge emu_clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic lvl, input int n);
    sig_in = lvl;
    step(n);
  endtask

  // One high/low cycle of the waveform; the rise optionally closes a period
  // whose expected result is queued (timed results also check latency).
  task automatic wave(input int hi, input int lo, input bit expect_res,
                      input int exp_p, input int exp_h, input bit timed);
    meas_t m;
    if (expect_res) begin
      m.period = exp_p;
      m.high   = exp_h;
      m.cyc    = timed ? cyc + LAT : -1;
      exp_q.push_back(m);
    end
    apply_stimulus(1'b1, hi);
    apply_stimulus(1'b0, lo);
  endtask

  task automatic do_reset();
    emu_rst = 1'b1;
    sig_in  = 1'b0;
    step(2);
    emu_rst = 1'b0;
    step(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_meas_period"}, meas_period, 0);
    check_output({tag, "_meas_high"},   meas_high,   0);
    check_output({tag, "_meas_valid"},  meas_valid,  0);
    check_output({tag, "_overrun"},     overrun,     0);
    check_output({tag, "_timeout"},     timeout,     0);
    check_output({tag, "_stuck_level"}, stuck_level, 0);
  endtask

  // Monitor: compare each accepted result and each timeout pulse.
  always @(negedge emu_clk) begin
    if (!emu_rst && meas_valid && meas_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL unexpected_result: got period=%0d high=%0d, expected none",
                 meas_period, meas_high);
      end else begin
        mon_m = exp_q.pop_front();
        check_output("meas_period", meas_period, mon_m.period);
        check_output("meas_high",   meas_high,   mon_m.high);
        if (mon_m.cyc >= 0) check_output("meas_latency", cyc, mon_m.cyc);
      end
    end
    if (!emu_rst && overrun) overrun_cnt++;
    if (!emu_rst && timeout) begin
      if (to_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL unexpected_timeout: got pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_t = to_q.pop_front();
        check_output("timeout_cycle", cyc,         mon_t.cyc);
        check_output("stuck_level",   stuck_level, mon_t.level);
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int    ov0;
    meas_t m;
    to_t   t;

    emu_rst    = 1'b1;
    sig_in     = 1'b0;
    meas_ready = 1'b0;
    step(2);
    check_reset_outputs("por");
    emu_rst = 1'b0;
    step(1);

    // Periodic 3 high / 5 low, consumer always ready.
    $display("[TB] scenario: 3/5 periodic");
    meas_ready = 1'b1;
    wave(3, 5, 1'b0, 0, 0, 1'b0);
    repeat (4) wave(3, 5, 1'b1, 8, 3, 1'b1);
    step(LAT + 1);

    // Minimum waveform 1 high / 1 low.
    $display("[TB] scenario: 1/1 minimum period");
    do_reset();
    wave(1, 1, 1'b0, 0, 0, 1'b0);
    repeat (6) wave(1, 1, 1'b1, 2, 1, 1'b1);
    step(LAT + 1);

    // Held result, overrun, then acceptance coinciding with a completion.
    $display("[TB] scenario: backpressure and overrun");
    do_reset();
    meas_ready = 1'b0;
    ov0 = overrun_cnt;
    wave(4, 4, 1'b0, 0, 0, 1'b0);
    wave(5, 3, 1'b1, 8, 4, 1'b0);
    wave(4, 6, 1'b0, 0, 0, 1'b0);
    check_output("overrun_once", overrun_cnt - ov0, 1);
    sig_in   = 1'b1;
    m.period = 10;
    m.high   = 4;
    m.cyc    = cyc + LAT;
    exp_q.push_back(m);
    step(SYNC_DLY);
    meas_ready = 1'b1;
    step(4 - SYNC_DLY);
    apply_stimulus(1'b0, 2);
    check_output("no_overrun_on_accept", overrun_cnt - ov0, 1);

    // Timeout while stuck high, restart from idle, then timeout while stuck low.
    $display("[TB] scenario: timeout");
    do_reset();
    t.cyc   = cyc + SYNC_DLY + 17;
    t.level = 1'b1;
    to_q.push_back(t);
    apply_stimulus(1'b1, 25);
    apply_stimulus(1'b0, 3);
    wave(2, 2, 1'b0, 0, 0, 1'b0);
    t.cyc   = cyc + SYNC_DLY + 17;
    t.level = 1'b0;
    to_q.push_back(t);
    wave(2, 2, 1'b1, 4, 2, 1'b1);
    apply_stimulus(1'b0, 20);
    check_output("stuck_level_low", stuck_level, 0);
    check_output("timeout_is_pulse", timeout, 0);

    // Asynchronous reset mid-LOW with a result pending.
    $display("[TB] scenario: async reset");
    do_reset();
    meas_ready = 1'b0;
    wave(3, 5, 1'b0, 0, 0, 1'b0);
    wave(3, 5, 1'b1, 8, 3, 1'b0);
    apply_stimulus(1'b1, 3);
    apply_stimulus(1'b0, 4);
    check_output("pending_before_reset", meas_valid, 1);
    #2;
    emu_rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    step(1);
    emu_rst    = 1'b0;
    meas_ready = 1'b1;
    step(1);
    wave(3, 5, 1'b0, 0, 0, 1'b0);
    wave(3, 5, 1'b1, 8, 3, 1'b1);
    step(LAT + 1);

    check_output("leftover_results",  exp_q.size(), 0);
    check_output("leftover_timeouts", to_q.size(),  0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
